// File: rtl/dma_block_mover.sv
// Byte-wide block copy / fill DMA engine for the CTI-8 system bus.
// Eight byte registers program it; it takes the shared bus via bus_req/bus_grant and drives memory cycles itself.
module dma_block_mover (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_sel,
   input  logic        reg_wr,
   input  logic [2:0]  reg_addr,
   input  logic [7:0]  reg_wdata,
   output logic [7:0]  reg_rdata,
   output logic        bus_req,
   input  logic        bus_grant,
   output logic [15:0] m_addr,
   output logic        m_oe,
   output logic        m_wr,
   output logic [7:0]  m_wdata,
   input  logic [7:0]  m_rdata,
   output logic        irq,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_READ   = 3'd2,
      S_WAIT   = 3'd3,
      S_WRITE  = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t      r_state;
   logic [15:0] r_src;
   logic [15:0] r_dst;
   logic [15:0] r_len;
   logic [7:0]  r_fill;
   logic        r_irq_en;
   logic        r_fill_mode;
   logic        r_busy;
   logic        r_done;
   logic        r_irq;
   logic        r_bus_req;
   logic        r_m_oe;
   logic        r_m_wr;
   logic [15:0] r_m_addr;
   logic [7:0]  r_m_wdata;

   logic        w_reg_wr;
   logic        w_ctrl_wr;
   logic        w_start;
   logic        w_status_rd;
   logic [15:0] w_src_inc;
   logic [15:0] w_dst_inc;
   logic [15:0] w_len_dec;

   assign w_reg_wr    = reg_sel & reg_wr;
   assign w_ctrl_wr   = w_reg_wr & (reg_addr == 3'd6);
   assign w_start     = w_ctrl_wr & reg_wdata[0];
   assign w_status_rd = reg_sel & ~reg_wr & (reg_addr == 3'd6);
   assign w_src_inc   = r_src + 16'd1;
   assign w_dst_inc   = r_dst + 16'd1;
   assign w_len_dec   = r_len - 16'd1;

   // Bus handshake: bus_req is held from START until the end of FINISH. A bus cycle counts only if
   // bus_grant is sampled high at the edge that closes it; a low grant sends the FSM back to REQ.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_src       <= 16'h0000;
         r_dst       <= 16'h0000;
         r_len       <= 16'h0000;
         r_fill      <= 8'h00;
         r_irq_en    <= 1'b0;
         r_fill_mode <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_irq       <= 1'b0;
         r_bus_req   <= 1'b0;
         r_m_oe      <= 1'b0;
         r_m_wr      <= 1'b0;
         r_m_addr    <= 16'h0000;
         r_m_wdata   <= 8'h00;
      end else begin
         if (w_reg_wr && !r_busy) begin
            case (reg_addr)
               3'd0:    r_src[7:0]  <= reg_wdata;
               3'd1:    r_src[15:8] <= reg_wdata;
               3'd2:    r_dst[7:0]  <= reg_wdata;
               3'd3:    r_dst[15:8] <= reg_wdata;
               3'd4:    r_len[7:0]  <= reg_wdata;
               3'd5:    r_len[15:8] <= reg_wdata;
               3'd7:    r_fill      <= reg_wdata;
               default: ;
            endcase
         end
         if (w_ctrl_wr && !(r_busy && reg_wdata[0])) begin
            r_irq_en    <= reg_wdata[1];
            r_fill_mode <= reg_wdata[2];
         end
         if (w_status_rd) begin
            r_done <= 1'b0;
            r_irq  <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_irq <= 1'b0;
                  if (r_len == 16'h0000) begin
                     r_state <= S_FINISH;
                  end else begin
                     r_done    <= 1'b0;
                     r_busy    <= 1'b1;
                     r_bus_req <= 1'b1;
                     r_state   <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (bus_grant) begin
                  r_m_oe   <= 1'b1;
                  r_m_addr <= r_fill_mode ? r_dst : r_src;
                  if (r_fill_mode) begin
                     r_m_wr    <= 1'b1;
                     r_m_wdata <= r_fill;
                     r_state   <= S_WRITE;
                  end else begin
                     r_m_wr  <= 1'b0;
                     r_state <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (!bus_grant) begin
                  r_m_oe  <= 1'b0;
                  r_m_wr  <= 1'b0;
                  r_state <= S_REQ;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!bus_grant) begin
                  r_m_oe  <= 1'b0;
                  r_m_wr  <= 1'b0;
                  r_state <= S_REQ;
               end else begin
                  // The write-data register doubles as the byte buffer.
                  r_m_wdata <= m_rdata;
                  r_m_wr    <= 1'b1;
                  r_m_addr  <= r_dst;
                  r_state   <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (!bus_grant) begin
                  r_m_oe  <= 1'b0;
                  r_m_wr  <= 1'b0;
                  r_state <= S_REQ;
               end else begin
                  r_dst <= w_dst_inc;
                  r_len <= w_len_dec;
                  if (!r_fill_mode) r_src <= w_src_inc;
                  if (w_len_dec == 16'h0000) begin
                     r_m_oe  <= 1'b0;
                     r_m_wr  <= 1'b0;
                     r_state <= S_FINISH;
                  end else if (r_fill_mode) begin
                     r_m_addr  <= w_dst_inc;
                     r_m_wdata <= r_fill;
                  end else begin
                     r_m_wr   <= 1'b0;
                     r_m_addr <= w_src_inc;
                     r_state  <= S_READ;
                  end
               end
            end
            S_FINISH: begin
               r_bus_req <= 1'b0;
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
               r_irq     <= r_irq_en;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      reg_rdata = 8'h00;
      case (reg_addr)
         3'd0:    reg_rdata = r_src[7:0];
         3'd1:    reg_rdata = r_src[15:8];
         3'd2:    reg_rdata = r_dst[7:0];
         3'd3:    reg_rdata = r_dst[15:8];
         3'd4:    reg_rdata = r_len[7:0];
         3'd5:    reg_rdata = r_len[15:8];
         3'd6:    reg_rdata = {4'h0, r_fill_mode, r_irq_en, r_done, r_busy};
         3'd7:    reg_rdata = r_fill;
         default: reg_rdata = 8'h00;
      endcase
   end

   assign bus_req   = r_bus_req;
   assign m_addr    = r_m_addr;
   assign m_oe      = r_m_oe;
   assign m_wr      = r_m_wr;
   assign m_wdata   = r_m_wdata;
   assign irq       = r_irq;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_dma_block_mover.sv
// Bench for dma_block_mover: a 64 KiB memory model on the master port, a write scoreboard,
// and directed copy / fill / wrap / grant-loss / edge-case transfers.
module tb_dma_block_mover;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_sel;
   logic        reg_wr;
   logic [2:0]  reg_addr;
   logic [7:0]  reg_wdata;
   logic [7:0]  reg_rdata;
   logic        bus_req;
   logic        bus_grant;
   logic [15:0] m_addr;
   logic        m_oe;
   logic        m_wr;
   logic [7:0]  m_wdata;
   logic [7:0]  m_rdata;
   logic        irq;
   logic [2:0]  dbg_state;

   logic [7:0]  mem [0:65535];
   logic [23:0] exp_q[$];
   logic [15:0] rd_addr_q[$];

   int checks = 0;
   int errors = 0;
   int n_rd, n_wr, t_rd0, t_wr0, t_wrl, t_irq;

   always #5 clk = ~clk;

   dma_block_mover dut (
      .clk       (clk),
      .rst       (rst),
      .reg_sel   (reg_sel),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .bus_req   (bus_req),
      .bus_grant (bus_grant),
      .m_addr    (m_addr),
      .m_oe      (m_oe),
      .m_wr      (m_wr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata),
      .irq       (irq),
      .dbg_state (dbg_state)
   );

   // Memory with one cycle of read latency; writes land only on granted cycles.
   always @(posedge clk) begin
      m_rdata <= mem[m_addr];
      if (m_oe && m_wr && bus_grant) mem[m_addr] = m_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every master write is popped against the expected {addr, data} queue.
   always @(negedge clk) begin
      if (!rst && m_oe && m_wr) begin
         if (exp_q.size() == 0) check("sb_extra_wr", {8'h00, m_addr, m_wdata}, 32'hFFFF_FFFF);
         else check("sb_wr", {8'h00, m_addr, m_wdata}, {8'h00, exp_q.pop_front()});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
      reg_sel   = 1'b1;
      reg_wr    = 1'b1;
      reg_addr  = a;
      reg_wdata = d;
      tick();
      reg_sel = 1'b0;
      reg_wr  = 1'b0;
   endtask

   task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
      reg_sel  = 1'b1;
      reg_wr   = 1'b0;
      reg_addr = a;
      #3;
      d = reg_rdata;
      tick();
      reg_sel = 1'b0;
   endtask

   task automatic peek(input logic [2:0] a, output logic [7:0] d);
      reg_sel  = 1'b0;
      reg_addr = a;
      #1;
      d = reg_rdata;
   endtask

   task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                        input logic [7:0] f);
      reg_write(3'd0, s[7:0]);
      reg_write(3'd1, s[15:8]);
      reg_write(3'd2, d[7:0]);
      reg_write(3'd3, d[15:8]);
      reg_write(3'd4, n[7:0]);
      reg_write(3'd5, n[15:8]);
      reg_write(3'd7, f);
   endtask

   task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n);
      logic [15:0] sa, da;
      for (int i = 0; i < n; i++) begin
         sa = s + 16'(i);
         da = d + 16'(i);
         exp_q.push_back({da, mem[sa]});
      end
   endtask

   task automatic push_fill(input logic [15:0] d, input int n, input logic [7:0] f);
      logic [15:0] da;
      for (int i = 0; i < n; i++) begin
         da = d + 16'(i);
         exp_q.push_back({da, f});
      end
   endtask

   // Watches a running transfer until STATUS shows DONE and not BUSY; optionally drops
   // bus_grant for two cycles starting in the drop_at-th non-write bus cycle.
   task automatic run_xfer(input int budget, input int drop_at);
      int cyc;
      int drop_left;
      n_rd = 0; n_wr = 0; t_rd0 = -1; t_wr0 = -1; t_wrl = -1; t_irq = -1;
      drop_left = 0;
      rd_addr_q.delete();
      reg_sel  = 1'b0;
      reg_addr = 3'd6;
      for (cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         if (drop_left > 0) begin
            drop_left--;
            check("drop_oe", m_oe, 0);
            check("drop_req", bus_req, 1);
            if (drop_left == 0) bus_grant = 1'b1;
         end
         if (m_oe && !m_wr) begin
            n_rd++;
            rd_addr_q.push_back(m_addr);
            if (t_rd0 < 0) t_rd0 = cyc;
            if (n_rd == drop_at) begin
               bus_grant = 1'b0;
               drop_left = 2;
            end
         end
         if (m_oe && m_wr) begin
            n_wr++;
            if (t_wr0 < 0) t_wr0 = cyc;
            t_wrl = cyc;
         end
         if (irq && t_irq < 0) t_irq = cyc;
         if (reg_rdata[1:0] == 2'b10) break;
      end
      check("xfer_timeout", (cyc > budget), 0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] st;
      logic [15:0] qa;
      rst       = 1'b1;
      reg_sel   = 1'b0;
      reg_wr    = 1'b0;
      reg_addr  = 3'd0;
      reg_wdata = 8'h00;
      bus_grant = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));

      // Reset state
      repeat (3) tick();
      check("rst_req", bus_req, 0);
      check("rst_oe", m_oe, 0);
      check("rst_wr", m_wr, 0);
      check("rst_addr", m_addr, 16'h0000);
      check("rst_wdata", m_wdata, 8'h00);
      check("rst_irq", irq, 0);
      rst = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         peek(3'(i), st);
         check("rst_reg", st, 8'h00);
      end

      // Copy 4 bytes 0x8000 -> 0x0100 with IRQ_EN
      setup(16'h8000, 16'h0100, 16'd4, 8'h00);
      push_copy(16'h8000, 16'h0100, 4);
      reg_write(3'd6, 8'h03);
      check("cp_req", bus_req, 1);
      run_xfer(100, 0);
      check("cp_nrd", n_rd, 8);
      check("cp_nwr", n_wr, 4);
      check("cp_first_rd", t_rd0, 2);
      // READ starts at cyc 2; 12 bus cycles after it ends, FINISH closes and irq appears.
      check("cp_irq_lat", t_irq - t_rd0 - 1, 12);
      check("cp_sb_empty", exp_q.size(), 0);
      check("cp_irq_set", irq, 1);
      reg_read(3'd6, st);
      check("cp_status", st, 8'h06);
      check("cp_irq_clr", irq, 0);
      peek(3'd6, st);
      check("cp_status_after", st, 8'h04);

      // Fill 3 bytes at 0x3FFE crossing a page
      setup(16'h0000, 16'h3FFE, 16'd3, 8'hA5);
      push_fill(16'h3FFE, 3, 8'hA5);
      reg_write(3'd6, 8'h05);
      run_xfer(100, 0);
      check("fl_nrd", n_rd, 0);
      check("fl_nwr", n_wr, 3);
      check("fl_first_wr", t_wr0, 2);
      check("fl_consec", t_wrl - t_wr0, 2);
      check("fl_sb_empty", exp_q.size(), 0);
      check("fl_irq", irq, 0);
      peek(3'd6, st);
      check("fl_status", st, 8'h0A);
      peek(3'd2, st);
      check("fl_dst_lo", st, 8'h01);
      peek(3'd3, st);
      check("fl_dst_hi", st, 8'h40);
      reg_read(3'd6, st);

      // Address wrap: 0xFFFF -> 0xFFFF, 2 bytes
      setup(16'hFFFF, 16'hFFFF, 16'd2, 8'h00);
      push_copy(16'hFFFF, 16'hFFFF, 2);
      reg_write(3'd6, 8'h01);
      run_xfer(100, 0);
      check("wr_nrd", n_rd, 4);
      qa = (rd_addr_q.size() > 2) ? rd_addr_q[2] : 16'hDEAD;
      check("wr_rd2_addr", qa, 16'h0000);
      check("wr_sb_empty", exp_q.size(), 0);
      peek(3'd0, st); check("wr_src_lo", st, 8'h01);
      peek(3'd1, st); check("wr_src_hi", st, 8'h00);
      peek(3'd2, st); check("wr_dst_lo", st, 8'h01);
      peek(3'd3, st); check("wr_dst_hi", st, 8'h00);
      peek(3'd4, st); check("wr_len_lo", st, 8'h00);
      reg_read(3'd6, st);

      // Grant loss during WAIT of byte 2 of 4
      setup(16'h8010, 16'h0200, 16'd4, 8'h00);
      push_copy(16'h8010, 16'h0200, 4);
      reg_write(3'd6, 8'h01);
      run_xfer(200, 4);
      check("gl_nrd", n_rd, 10);
      check("gl_nwr", n_wr, 4);
      qa = (rd_addr_q.size() > 4) ? rd_addr_q[4] : 16'hDEAD;
      check("gl_reread", qa, 16'h8011);
      check("gl_sb_empty", exp_q.size(), 0);
      reg_read(3'd6, st);
      check("gl_status", st, 8'h02);

      // LEN == 0 START: DONE without touching the bus
      reg_write(3'd4, 8'h00);
      reg_write(3'd5, 8'h00);
      reg_write(3'd6, 8'h01);
      check("z_req0", bus_req, 0);
      peek(3'd6, st);
      check("z_done_early", st, 8'h00);
      tick();
      check("z_req1", bus_req, 0);
      peek(3'd6, st);
      check("z_status", st, 8'h02);
      tick();
      check("z_req2", bus_req, 0);
      reg_read(3'd6, st);

      // START while BUSY ignored; CTRL without START still lands
      setup(16'h8020, 16'h0300, 16'd4, 8'h00);
      push_copy(16'h8020, 16'h0300, 4);
      reg_write(3'd6, 8'h01);
      reg_write(3'd0, 8'h55);
      reg_write(3'd6, 8'h07);
      reg_write(3'd6, 8'h02);
      run_xfer(200, 0);
      check("bz_sb_empty", exp_q.size(), 0);
      peek(3'd6, st); check("bz_status", st, 8'h06);
      check("bz_irq", irq, 1);
      peek(3'd0, st); check("bz_src_lo", st, 8'h24);
      peek(3'd1, st); check("bz_src_hi", st, 8'h80);
      reg_read(3'd6, st);

      // Reset in the middle of a transfer
      setup(16'h8040, 16'h0400, 16'd8, 8'h3C);
      push_copy(16'h8040, 16'h0400, 8);
      reg_write(3'd6, 8'h03);
      repeat (5) tick();
      check("mr_busy_before", bus_req, 1);
      rst = 1'b1;
      tick();
      check("mr_req", bus_req, 0);
      check("mr_oe", m_oe, 0);
      check("mr_wr", m_wr, 0);
      check("mr_irq", irq, 0);
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         peek(3'(i), st);
         check("mr_reg", st, 8'h00);
      end
      repeat (4) tick();
      check("mr_idle_req", bus_req, 0);

      check("sb_final_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
